// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN stack controller: command opcodes,
// error codes and controller FSM states.
`timescale 1ns/1ps

package rpn_pkg;

    // Command opcodes carried on i_cmd_op
    typedef enum logic [1:0] {
        CMD_PUSH  = 2'b00,
        CMD_POP   = 2'b01,
        CMD_OP    = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    // Error codes reported on o_err_code; the last error wins
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_UNF  = 2'b10,
        ERR_ALU  = 2'b11
    } err_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ALU_WAIT = 2'b01,
        ST_WRITE    = 2'b10
    } state_e;

endpackage : rpn_pkg

// File: rtl/rpn_stack_ctrl.sv
// RPN operand-stack controller. Runs a 2-read/1-write reg_file as a stack:
// accepts PUSH/POP/OP/CLEAR commands, tracks depth, and for OP fetches
// NOS/TOS, hands them to the ALU and writes the result back over NOS.
`timescale 1ns/1ps

module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int REG_WIDTH   = 4,
    parameter int NUM_REGS    = 4,
    parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter int DEPTH_WIDTH = $clog2(NUM_REGS + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,

    // Command interface
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [1:0]             i_cmd_op,
    input  logic [REG_WIDTH-1:0]   i_cmd_data,

    // reg_file interface
    output logic                   o_rf_wr_en,
    output logic [ADDR_WIDTH-1:0]  o_rf_wr_addr,
    output logic [REG_WIDTH-1:0]   o_rf_wr_data,
    output logic [ADDR_WIDTH-1:0]  o_rf_rd_addr_a,
    input  logic [REG_WIDTH-1:0]   i_rf_rd_data_a,
    output logic [ADDR_WIDTH-1:0]  o_rf_rd_addr_b,
    input  logic [REG_WIDTH-1:0]   i_rf_rd_data_b,

    // ALU interface
    output logic                   o_alu_start,
    output logic [REG_WIDTH-1:0]   o_alu_a,
    output logic [REG_WIDTH-1:0]   o_alu_b,
    input  logic                   i_alu_done,
    input  logic [REG_WIDTH-1:0]   i_alu_result,
    input  logic                   i_alu_err,

    // Status
    output logic [REG_WIDTH-1:0]   o_top,
    output logic [DEPTH_WIDTH-1:0] o_depth,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_err,
    output logic [1:0]             o_err_code
);

    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE  = DEPTH_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_TWO  = DEPTH_WIDTH'(2);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_FULL = DEPTH_WIDTH'(NUM_REGS);

    state_e                  state_q,     state_d;
    logic [DEPTH_WIDTH-1:0]  depth_q,     depth_d;
    logic                    err_q,       err_d;
    err_e                    err_code_q,  err_code_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q,   wr_addr_d;
    logic [REG_WIDTH-1:0]    wr_data_q,   wr_data_d;
    logic [REG_WIDTH-1:0]    alu_a_q,     alu_a_d;
    logic [REG_WIDTH-1:0]    alu_b_q,     alu_b_d;
    logic                    alu_start_q, alu_start_d;
    // Remembers whether the pending WRITE grows (PUSH) or shrinks (OP) the stack
    logic                    wr_push_q,   wr_push_d;

    logic                    empty;
    logic                    full;
    logic                    has_two;
    logic [ADDR_WIDTH-1:0]   tos_addr;
    logic [ADDR_WIDTH-1:0]   nos_addr;

    // Stack pointers derived from depth; parked at 0 when the slot does not exist
    always_comb begin
        empty    = (depth_q == '0);
        full     = (depth_q == DEPTH_FULL);
        has_two  = (depth_q >= DEPTH_TWO);
        tos_addr = empty   ? '0 : ADDR_WIDTH'(depth_q - DEPTH_ONE);
        nos_addr = has_two ? ADDR_WIDTH'(depth_q - DEPTH_TWO) : '0;
    end

    // Next-state, stack-depth and error logic for the IDLE/ALU_WAIT/WRITE sequence
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d     = state_q;
        depth_d     = depth_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_start_d = 1'b0;
        wr_push_d   = wr_push_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    unique case (cmd_e'(i_cmd_op))
                        CMD_PUSH: begin
                            if (full) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_OVF;
                            end else begin
                                // depth < NUM_REGS here, so it fits the address width
                                wr_addr_d = ADDR_WIDTH'(depth_q);
                                wr_data_d = i_cmd_data;
                                wr_push_d = 1'b1;
                                state_d   = ST_WRITE;
                            end
                        end
                        CMD_POP: begin
                            if (empty) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_UNF;
                            end else begin
                                depth_d = depth_q - DEPTH_ONE;
                            end
                        end
                        CMD_OP: begin
                            if (!has_two) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_UNF;
                            end else begin
                                // Operands in a-b order: a is NOS, b is TOS
                                alu_a_d     = i_rf_rd_data_b;
                                alu_b_d     = i_rf_rd_data_a;
                                alu_start_d = 1'b1;
                                wr_push_d   = 1'b0;
                                state_d     = ST_ALU_WAIT;
                            end
                        end
                        CMD_CLEAR: begin
                            depth_d    = '0;
                            err_d      = 1'b0;
                            err_code_d = ERR_NONE;
                        end
                        default: ;
                    endcase
                end
            end

            ST_ALU_WAIT: begin
                // No timeout: the ALU owns the latency
                if (i_alu_done) begin
                    if (i_alu_err) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ALU;
                        state_d    = ST_IDLE;
                    end else begin
                        wr_addr_d = nos_addr;
                        wr_data_d = i_alu_result;
                        state_d   = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                // The reg_file commits on this exit edge, so depth moves with it
                // and o_top never shows a stale entry.
                depth_d = wr_push_q ? depth_q + DEPTH_ONE : depth_q - DEPTH_ONE;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers; reset aborts any ALU_WAIT/WRITE in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            depth_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_start_q <= 1'b0;
            wr_push_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_start_q <= alu_start_d;
            wr_push_q   <= wr_push_d;
        end
    end

    // NOTE: reg_file contents are never reset; depth 0 makes every entry unreachable.
    assign o_cmd_ready    = (state_q == ST_IDLE);
    assign o_rf_wr_en     = (state_q == ST_WRITE);
    assign o_rf_wr_addr   = wr_addr_q;
    assign o_rf_wr_data   = wr_data_q;
    assign o_rf_rd_addr_a = tos_addr;
    assign o_rf_rd_addr_b = nos_addr;
    assign o_alu_start    = alu_start_q;
    assign o_alu_a        = alu_a_q;
    assign o_alu_b        = alu_b_q;
    assign o_top          = empty ? '0 : i_rf_rd_data_a;
    assign o_depth        = depth_q;
    assign o_empty        = empty;
    assign o_full         = full;
    assign o_err          = err_q;
    assign o_err_code     = err_code_q;

endmodule : rpn_stack_ctrl

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: behavioural reg_file and ALU, a queue-based stack
// model, one per-cycle compare process, directed pins and random commands.
`timescale 1ns/1ps

module tb_rpn_stack_ctrl;
    import rpn_pkg::*;

    localparam int RW = 4;
    localparam int NR = 4;
    localparam int AW = 2;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_op;
    logic [RW-1:0] i_cmd_data;
    logic          o_rf_wr_en;
    logic [AW-1:0] o_rf_wr_addr;
    logic [RW-1:0] o_rf_wr_data;
    logic [AW-1:0] o_rf_rd_addr_a;
    logic [RW-1:0] i_rf_rd_data_a;
    logic [AW-1:0] o_rf_rd_addr_b;
    logic [RW-1:0] i_rf_rd_data_b;
    logic          o_alu_start;
    logic [RW-1:0] o_alu_a;
    logic [RW-1:0] o_alu_b;
    logic          i_alu_done;
    logic [RW-1:0] i_alu_result;
    logic          i_alu_err;
    logic [RW-1:0] o_top;
    logic [DW-1:0] o_depth;
    logic          o_empty;
    logic          o_full;
    logic          o_err;
    logic [1:0]    o_err_code;

    always #5 clk = ~clk;

    rpn_stack_ctrl #(.REG_WIDTH(RW), .NUM_REGS(NR)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_op       (i_cmd_op),
        .i_cmd_data     (i_cmd_data),
        .o_rf_wr_en     (o_rf_wr_en),
        .o_rf_wr_addr   (o_rf_wr_addr),
        .o_rf_wr_data   (o_rf_wr_data),
        .o_rf_rd_addr_a (o_rf_rd_addr_a),
        .i_rf_rd_data_a (i_rf_rd_data_a),
        .o_rf_rd_addr_b (o_rf_rd_addr_b),
        .i_rf_rd_data_b (i_rf_rd_data_b),
        .o_alu_start    (o_alu_start),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .i_alu_done     (i_alu_done),
        .i_alu_result   (i_alu_result),
        .i_alu_err      (i_alu_err),
        .o_top          (o_top),
        .o_depth        (o_depth),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_err          (o_err),
        .o_err_code     (o_err_code)
    );

    // Behavioural reg_file: synchronous write, asynchronous read
    logic [RW-1:0] rf_mem [NR];
    always @(posedge clk) if (o_rf_wr_en) rf_mem[o_rf_wr_addr] <= o_rf_wr_data;
    assign i_rf_rd_data_a = rf_mem[o_rf_rd_addr_a];
    assign i_rf_rd_data_b = rf_mem[o_rf_rd_addr_b];

    // Reference model: the stack as a queue plus expected handshake outputs
    int stk[$];
    bit m_err;
    int m_code;
    bit exp_ready, exp_wr_en, exp_start;
    int exp_wr_addr, exp_wr_data, exp_a, exp_b;
    bit cmp_en;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge clk) begin : compare
        int d;
        d = stk.size();
        if (cmp_en) begin
            check("depth",     int'(o_depth),        d);
            check("top",       int'(o_top),          (d > 0) ? stk[d-1] : 0);
            check("empty",     int'(o_empty),        int'(d == 0));
            check("full",      int'(o_full),         int'(d == NR));
            check("err",       int'(o_err),          int'(m_err));
            check("err_code",  int'(o_err_code),     m_code);
            check("ready",     int'(o_cmd_ready),    int'(exp_ready));
            check("wr_en",     int'(o_rf_wr_en),     int'(exp_wr_en));
            check("alu_start", int'(o_alu_start),    int'(exp_start));
            check("rd_addr_a", int'(o_rf_rd_addr_a), (d > 0) ? d - 1 : 0);
            check("rd_addr_b", int'(o_rf_rd_addr_b), (d > 1) ? d - 2 : 0);
            if (exp_wr_en) begin
                check("wr_addr", int'(o_rf_wr_addr), exp_wr_addr);
                check("wr_data", int'(o_rf_wr_data), exp_wr_data);
            end
            if (exp_start) begin
                check("alu_a", int'(o_alu_a), exp_a);
                check("alu_b", int'(o_alu_b), exp_b);
            end
        end
    end

    task automatic set_err(input int code);
        m_err  = 1'b1;
        m_code = code;
    endtask

    // Drive junk while the controller is busy; it must not be accepted
    task automatic junk();
        i_cmd_valid  = 1'($urandom_range(0, 1));
        i_cmd_op     = 2'($urandom_range(0, 3));
        i_cmd_data   = RW'($urandom_range(0, 15));
        i_alu_err    = 1'($urandom_range(0, 1));
        i_alu_result = RW'($urandom_range(0, 15));
    endtask

    // One WRITE cycle with noise on command and done lines
    task automatic write_cycle();
        junk();
        i_alu_done = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        i_alu_done  = 1'b0;
    endtask

    // Issue one command in IDLE and follow it to completion
    task automatic do_cmd(input int op, input int data, input int lat, input bit aerr);
        int n, a, b, res;
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'(op);
        i_cmd_data  = RW'(data);
        i_alu_done  = 1'b0;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        n = stk.size();
        case (op)
            0: begin
                if (n == NR) set_err(1);
                else begin
                    exp_ready = 1'b0; exp_wr_en = 1'b1;
                    exp_wr_addr = n; exp_wr_data = data;
                    write_cycle();
                    stk.push_back(data);
                    exp_wr_en = 1'b0; exp_ready = 1'b1;
                end
            end
            1: begin
                if (n == 0) set_err(2);
                else void'(stk.pop_back());
            end
            2: begin
                if (n < 2) set_err(2);
                else begin
                    a = stk[n-2];
                    b = stk[n-1];
                    res = (a + b) % 16;
                    exp_ready = 1'b0; exp_start = 1'b1; exp_a = a; exp_b = b;
                    for (int k = 0; k <= lat; k++) begin
                        junk();
                        if (k == lat) begin
                            i_alu_done   = 1'b1;
                            i_alu_err    = aerr;
                            i_alu_result = RW'(res);
                        end else begin
                            i_alu_done = 1'b0;
                        end
                        @(posedge clk); #1;
                        exp_start = 1'b0;
                    end
                    i_alu_done  = 1'b0;
                    i_cmd_valid = 1'b0;
                    if (aerr) begin
                        set_err(3);
                        exp_ready = 1'b1;
                    end else begin
                        exp_wr_en = 1'b1; exp_wr_addr = n - 2; exp_wr_data = res;
                        write_cycle();
                        void'(stk.pop_back());
                        void'(stk.pop_back());
                        stk.push_back(res);
                        exp_wr_en = 1'b0; exp_ready = 1'b1;
                    end
                end
            end
            default: begin
                stk.delete();
                m_err  = 1'b0;
                m_code = 0;
            end
        endcase
    endtask

    initial begin
        rst_n = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_op = 2'b00; i_cmd_data = '0;
        i_alu_done = 1'b0; i_alu_result = '0; i_alu_err = 1'b0;
        m_err = 1'b0; m_code = 0;
        exp_ready = 1'b1; exp_wr_en = 1'b0; exp_start = 1'b0;
        exp_wr_addr = 0; exp_wr_data = 0; exp_a = 0; exp_b = 0;
        cmp_en = 1'b0;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready", int'(o_cmd_ready), 1);
        check("rst_empty", int'(o_empty), 1);
        check("rst_code",  int'(o_err_code), 0);

        // 1: PUSH 3, PUSH 5
        do_cmd(0, 3, 0, 0);
        do_cmd(0, 5, 0, 0);
        check("t1_depth", int'(o_depth), 2);
        check("t1_top",   int'(o_top), 5);
        check("t1_rf0",   int'(rf_mem[0]), 3);
        check("t1_rf1",   int'(rf_mem[1]), 5);

        // 3: OP on [3,5], done 3 cycles after start, result 8
        do_cmd(2, 0, 3, 0);
        check("t3_depth", int'(o_depth), 1);
        check("t3_top",   int'(o_top), 8);
        check("t3_rf0",   int'(rf_mem[0]), 8);

        // 2: fill, then overflow
        do_cmd(3, 0, 0, 0);
        for (int i = 1; i <= 4; i++) do_cmd(0, i, 0, 0);
        check("t2_full", int'(o_full), 1);
        do_cmd(0, 7, 0, 0);
        check("t2_err",   int'(o_err), 1);
        check("t2_code",  int'(o_err_code), 1);
        check("t2_depth", int'(o_depth), 4);
        check("t2_top",   int'(o_top), 4);

        // 4: underflows and CLEAR
        do_cmd(3, 0, 0, 0);
        do_cmd(1, 0, 0, 0);
        check("t4_pop_code", int'(o_err_code), 2);
        do_cmd(0, 2, 0, 0);
        do_cmd(2, 0, 1, 0);
        check("t4_op_code",  int'(o_err_code), 2);
        check("t4_op_depth", int'(o_depth), 1);
        do_cmd(3, 0, 0, 0);
        check("t4_clr_err",   int'(o_err), 0);
        check("t4_clr_depth", int'(o_depth), 0);
        check("t4_clr_empty", int'(o_empty), 1);

        // 5: ALU error on [4,0]
        do_cmd(0, 4, 0, 0);
        do_cmd(0, 0, 0, 0);
        do_cmd(2, 0, 2, 1);
        check("t5_code",  int'(o_err_code), 3);
        check("t5_depth", int'(o_depth), 2);
        check("t5_top",   int'(o_top), 0);

        // 6: reset during ALU_WAIT, then a late done
        do_cmd(3, 0, 0, 0);
        do_cmd(0, 6, 0, 0);
        do_cmd(0, 9, 0, 0);
        i_cmd_valid = 1'b1; i_cmd_op = 2'b10;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        exp_ready = 1'b0; exp_start = 1'b1; exp_a = 6; exp_b = 9;
        @(posedge clk); #1;
        exp_start = 1'b0;
        rst_n = 1'b0;
        stk.delete(); m_err = 1'b0; m_code = 0; exp_ready = 1'b1;
        #1;
        check("t6_rst_ready", int'(o_cmd_ready), 1);
        check("t6_rst_depth", int'(o_depth), 0);
        check("t6_rst_alu_a", int'(o_alu_a), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        i_alu_done = 1'b1; i_alu_result = 4'd15; i_alu_err = 1'b0;
        @(posedge clk); #1;
        i_alu_done = 1'b0;
        @(posedge clk); #1;
        check("t6_late_ready", int'(o_cmd_ready), 1);
        check("t6_late_depth", int'(o_depth), 0);
        check("t6_late_empty", int'(o_empty), 1);

        // Random command stream
        for (int c = 0; c < 400; c++) begin
            int r, op, gap;
            r = $urandom_range(0, 9);
            op = (r < 4) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                i_alu_done = 1'($urandom_range(0, 1));
                i_alu_err  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                i_alu_done = 1'b0;
            end
            do_cmd(op, $urandom_range(0, 15), $urandom_range(0, 3),
                   ($urandom_range(0, 5) == 0));
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rpn_stack_ctrl
